// File: rtl/mem_port_ctrl.sv
// Host initiator for one ECC memory port: Hamming(12,8) encode on write, SEC decode on read.
// Read response RL+1 edges after accept, write ack WL edges after; reads stall while a write is in flight.
module mem_port_ctrl #(
    parameter int D_W = 8,
    parameter int R_W = 12,
    parameter int A_W = 10,
    parameter int WL  = 2,
    parameter int RL  = 2
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_req_valid,
    output logic             o_req_ready,
    input  logic             in_req_we,
    input  logic [A_W-3:0]   in_req_addr,
    input  logic [D_W-1:0]   in_req_wdata,
    output logic             o_rsp_valid,
    output logic [D_W-1:0]   o_rsp_rdata,
    output logic             o_rsp_corr,
    output logic             o_rsp_uncorr,
    output logic             o_wr_ack,
    output logic [7:0]       o_corr_cnt,
    output logic             o_mem_en,
    output logic             o_mem_we,
    output logic [A_W-3:0]   o_mem_addr,
    output logic [R_W-1:0]   o_mem_din,
    input  logic [R_W-1:0]   in_mem_dout
);

    localparam int BW = $clog2(WL + 1);

    // Parity p1/p2/p4/p8 live in bits 0/1/3/7; data fills the remaining positions in order.
    function automatic logic [11:0] hamming_enc(input logic [7:0] d);
        logic [11:0] c;
        c     = '0;
        c[2]  = d[0];
        c[4]  = d[1];
        c[5]  = d[2];
        c[6]  = d[3];
        c[8]  = d[4];
        c[9]  = d[5];
        c[10] = d[6];
        c[11] = d[7];
        c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
        c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
        return c;
    endfunction

    logic [BW-1:0]   wr_busy_q, wr_busy_d;
    logic [WL-1:0]   wr_sr_q, wr_sr_d;
    logic [RL:0]     rd_sr_q, rd_sr_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [A_W-3:0]  mem_addr_q, mem_addr_d;
    logic [R_W-1:0]  mem_din_q, mem_din_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [D_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic            rsp_corr_q, rsp_corr_d;
    logic            rsp_uncorr_q, rsp_uncorr_d;
    logic            wr_ack_q, wr_ack_d;
    logic [7:0]      corr_cnt_q, corr_cnt_d;

    logic            acc, acc_wr, acc_rd;
    logic [3:0]      syn;
    logic [11:0]     fixed_word;
    logic            dec_corr, dec_uncorr;
    logic [7:0]      dec_data;

    assign o_req_ready = !in_rst && (in_req_we || (wr_busy_q == '0));
    assign acc         = in_req_valid && o_req_ready;
    assign acc_wr      = acc && in_req_we;
    assign acc_rd      = acc && !in_req_we;

    always_comb begin
        syn[0] = ^{in_mem_dout[0], in_mem_dout[2], in_mem_dout[4], in_mem_dout[6], in_mem_dout[8], in_mem_dout[10]};
        syn[1] = ^{in_mem_dout[1], in_mem_dout[2], in_mem_dout[5], in_mem_dout[6], in_mem_dout[9], in_mem_dout[10]};
        syn[2] = ^{in_mem_dout[3], in_mem_dout[4], in_mem_dout[5], in_mem_dout[6], in_mem_dout[11]};
        syn[3] = ^{in_mem_dout[7], in_mem_dout[8], in_mem_dout[9], in_mem_dout[10], in_mem_dout[11]};
        fixed_word = in_mem_dout;
        for (int i = 0; i < 12; i++) begin
            if (syn == 4'(i + 1)) begin
                fixed_word[i] = ~in_mem_dout[i];
            end
        end
        dec_corr   = (syn != 4'd0) && (syn <= 4'd12);
        dec_uncorr = (syn > 4'd12);
        dec_data   = {fixed_word[11], fixed_word[10], fixed_word[9], fixed_word[8],
                      fixed_word[6], fixed_word[5], fixed_word[4], fixed_word[2]};
    end

    always_comb begin
        wr_busy_d = wr_busy_q;
        if (acc_wr) begin
            wr_busy_d = BW'(WL);
        end else if (wr_busy_q != '0) begin
            wr_busy_d = wr_busy_q - BW'(1);
        end

        // One bit per in-flight op so back-to-back writes and reads each get their own pulse.
        wr_sr_d    = wr_sr_q << 1;
        wr_sr_d[0] = acc_wr;
        rd_sr_d    = rd_sr_q << 1;
        rd_sr_d[0] = acc_rd;

        mem_en_d   = acc;
        mem_we_d   = acc_wr;
        mem_addr_d = acc ? in_req_addr : '0;
        mem_din_d  = acc_wr ? hamming_enc(in_req_wdata) : '0;

        wr_ack_d     = wr_sr_q[WL-1];
        rsp_valid_d  = rd_sr_q[RL];
        rsp_rdata_d  = rd_sr_q[RL] ? dec_data : '0;
        rsp_corr_d   = rd_sr_q[RL] && dec_corr;
        rsp_uncorr_d = rd_sr_q[RL] && dec_uncorr;

        corr_cnt_d = corr_cnt_q;
        if (rd_sr_q[RL] && dec_corr && (corr_cnt_q != 8'hFF)) begin
            corr_cnt_d = corr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            wr_busy_q    <= '0;
            wr_sr_q      <= '0;
            rd_sr_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_corr_q   <= 1'b0;
            rsp_uncorr_q <= 1'b0;
            wr_ack_q     <= 1'b0;
            corr_cnt_q   <= '0;
        end else begin
            wr_busy_q    <= wr_busy_d;
            wr_sr_q      <= wr_sr_d;
            rd_sr_q      <= rd_sr_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_corr_q   <= rsp_corr_d;
            rsp_uncorr_q <= rsp_uncorr_d;
            wr_ack_q     <= wr_ack_d;
            corr_cnt_q   <= corr_cnt_d;
        end
    end

    assign o_mem_en     = mem_en_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_din    = mem_din_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_rdata  = rsp_rdata_q;
    assign o_rsp_corr   = rsp_corr_q;
    assign o_rsp_uncorr = rsp_uncorr_q;
    assign o_wr_ack     = wr_ack_q;
    assign o_corr_cnt   = corr_cnt_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: behavioural memory with injectable read words and a cycle-level reference model.
module tb_mem_port_ctrl;

    localparam int WL = 2;
    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        in_rst;
    logic        in_req_valid;
    logic        o_req_ready;
    logic        in_req_we;
    logic [7:0]  in_req_addr;
    logic [7:0]  in_req_wdata;
    logic        o_rsp_valid;
    logic [7:0]  o_rsp_rdata;
    logic        o_rsp_corr;
    logic        o_rsp_uncorr;
    logic        o_wr_ack;
    logic [7:0]  o_corr_cnt;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [7:0]  o_mem_addr;
    logic [11:0] o_mem_din;
    logic [11:0] in_mem_dout;

    always #5 clk = ~clk;

    mem_port_ctrl #(.D_W(8), .R_W(12), .A_W(10), .WL(WL), .RL(RL)) dut (
        .in_clk(clk), .in_rst(in_rst),
        .in_req_valid(in_req_valid), .o_req_ready(o_req_ready), .in_req_we(in_req_we),
        .in_req_addr(in_req_addr), .in_req_wdata(in_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_corr(o_rsp_corr),
        .o_rsp_uncorr(o_rsp_uncorr), .o_wr_ack(o_wr_ack), .o_corr_cnt(o_corr_cnt),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_din(o_mem_din), .in_mem_dout(in_mem_dout)
    );

    // Memory port: samples one edge after the controller registers the request.
    logic [11:0] mem       [256];
    logic        inj_en    [256];
    logic [11:0] inj_val   [256];
    logic [11:0] rpipe     [RL];
    logic        wv0;
    logic [7:0]  wa0;
    logic [11:0] wd0;

    always @(posedge clk) begin
        if (wv0) mem[wa0] <= wd0;
        wv0 <= o_mem_en && o_mem_we;
        wa0 <= o_mem_addr;
        wd0 <= o_mem_din;
        rpipe[0] <= inj_en[o_mem_addr] ? inj_val[o_mem_addr] : mem[o_mem_addr];
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign in_mem_dout = rpipe[RL-1];

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       corr;
        logic       uncorr;
    } rsp_t;

    int          errors = 0;
    int          checks = 0;
    int          edge_n = 0;
    int          last_wr = -1000;
    int          cnt_m = 0;
    int          rsp_seen = 0;
    rsp_t        rq[$];
    int          wq[$];
    logic        acc_v = 1'b0;
    logic        acc_we = 1'b0;
    logic [7:0]  acc_a = '0;
    logic [11:0] acc_din = '0;
    logic [7:0]  shadow [256];

    function automatic logic [11:0] enc(input logic [7:0] d);
        logic [11:0] c;
        logic        par;
        int          j;
        c = '0;
        j = 0;
        for (int p = 1; p <= 12; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 12; p++) begin
                if (p[k] && ((p & (p - 1)) != 0)) par ^= c[p-1];
            end
            c[(1 << k) - 1] = par;
        end
        return c;
    endfunction

    function automatic rsp_t dec(input logic [11:0] w);
        rsp_t r;
        int   syn;
        int   j;
        syn = 0;
        for (int p = 1; p <= 12; p++) if (w[p-1]) syn ^= p;
        r.due    = 0;
        r.corr   = 1'b0;
        r.uncorr = 1'b0;
        if (syn >= 1 && syn <= 12) begin
            w[syn-1] = ~w[syn-1];
            r.corr   = 1'b1;
        end else if (syn > 12) begin
            r.uncorr = 1'b1;
        end
        r.data = '0;
        j = 0;
        for (int p = 1; p <= 12; p++) begin
            if ((p & (p - 1)) != 0) begin
                r.data[j] = w[p-1];
                j++;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Runs at the negedge after edge edge_n: checks outputs, then books the accept for the next edge.
    task automatic model_check();
        rsp_t        r;
        logic        exp_rsp;
        logic        exp_ack;
        logic        exp_rdy;
        logic [11:0] w;
        edge_n++;
        if (in_rst) begin
            chk("rst_ready",  32'(o_req_ready),  32'(0));
            chk("rst_mem_en", 32'(o_mem_en),     32'(0));
            chk("rst_mem_we", 32'(o_mem_we),     32'(0));
            chk("rst_rsp_v",  32'(o_rsp_valid),  32'(0));
            chk("rst_ack",    32'(o_wr_ack),     32'(0));
            chk("rst_cnt",    32'(o_corr_cnt),   32'(0));
            chk("rst_rdata",  32'(o_rsp_rdata),  32'(0));
            chk("rst_din",    32'(o_mem_din),    32'(0));
            rq.delete();
            wq.delete();
            acc_v   = 1'b0;
            last_wr = -1000;
            cnt_m   = 0;
            return;
        end
        chk("mem_en", 32'(o_mem_en), 32'(acc_v));
        chk("mem_we", 32'(o_mem_we), 32'(acc_v && acc_we));
        if (acc_v) chk("mem_addr", 32'(o_mem_addr), 32'(acc_a));
        if (acc_v && acc_we) chk("mem_din", 32'(o_mem_din), 32'(acc_din));

        exp_ack = (wq.size() > 0) && (wq[0] == edge_n);
        if (exp_ack) void'(wq.pop_front());
        chk("wr_ack", 32'(o_wr_ack), 32'(exp_ack));

        exp_rsp = (rq.size() > 0) && (rq[0].due == edge_n);
        chk("rsp_valid", 32'(o_rsp_valid), 32'(exp_rsp));
        if (o_rsp_valid) rsp_seen++;
        if (exp_rsp) begin
            r = rq.pop_front();
            if (r.corr && cnt_m < 255) cnt_m++;
            chk("rsp_rdata",  32'(o_rsp_rdata),  32'(r.data));
            chk("rsp_corr",   32'(o_rsp_corr),   32'(r.corr));
            chk("rsp_uncorr", 32'(o_rsp_uncorr), 32'(r.uncorr));
        end
        chk("corr_cnt", 32'(o_corr_cnt), 32'(cnt_m));

        exp_rdy = in_req_we || (edge_n + 1 >= last_wr + WL + 1);
        chk("req_ready", 32'(o_req_ready), 32'(exp_rdy));
        acc_v  = in_req_valid && exp_rdy;
        acc_we = in_req_we;
        acc_a  = in_req_addr;
        if (acc_v && in_req_we) begin
            acc_din = enc(in_req_wdata);
            shadow[in_req_addr] = in_req_wdata;
            last_wr = edge_n + 1;
            wq.push_back(edge_n + 1 + WL);
        end
        if (acc_v && !in_req_we) begin
            w = inj_en[in_req_addr] ? inj_val[in_req_addr] : enc(shadow[in_req_addr]);
            r = dec(w);
            r.due = edge_n + 1 + RL + 1;
            rq.push_back(r);
        end
    endtask

    task automatic step(input logic v, input logic we, input logic [7:0] a,
                        input logic [7:0] d, input logic rst);
        @(posedge clk);
        #1;
        in_rst       = rst;
        in_req_valid = v;
        in_req_we    = we;
        in_req_addr  = a;
        in_req_wdata = d;
        @(negedge clk);
        model_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b1, 1'b0, a, 8'd0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rsp_t        pr;
        int          n_wait;
        logic [7:0]  ra;
        in_rst = 1'b1; in_req_valid = 1'b0; in_req_we = 1'b0;
        in_req_addr = '0; in_req_wdata = '0;
        for (int a = 0; a < 256; a++) begin
            inj_en[a]  = 1'b0;
            inj_val[a] = '0;
            shadow[a]  = '0;
        end
        inj_en[200] = 1'b1; inj_val[200] = enc(8'($urandom)) ^ (12'h1 << $urandom_range(0, 11));
        inj_en[201] = 1'b1; inj_val[201] = 12'($urandom);
        inj_en[202] = 1'b1; inj_val[202] = 12'h027;
        inj_en[203] = 1'b1; inj_val[203] = 12'h803;

        // Pin the reference model to hand-worked codewords.
        chk("pin_enc01", 32'(enc(8'h01)), 32'h007);
        chk("pin_encff", 32'(enc(8'hFF)), 32'hF77);
        pr = dec(12'h027);
        chk("pin_dec027", {23'd0, pr.corr, pr.data}, {23'd0, 1'b1, 8'h01});
        pr = dec(12'h803);
        chk("pin_dec803", {22'd0, pr.uncorr, pr.corr, pr.data}, {22'd0, 1'b1, 1'b0, 8'h80});

        repeat (3) step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        chk("lit_rst_ready", 32'(o_req_ready), 32'(0));
        idle(1);
        chk("lit_ready_after_rst", 32'(o_req_ready), 32'(1));

        for (int a = 0; a < 256; a++) wr(8'(a), 8'($urandom));
        idle(4);

        wr(8'd5, 8'h01);
        idle(1);
        chk("lit_w01_din", 32'(o_mem_din), 32'h007);
        chk("lit_w01_we",  32'(o_mem_we),  32'(1));
        idle(2);
        chk("lit_w01_ack", 32'(o_wr_ack),  32'(1));
        rd(8'd5);
        idle(5);
        chk("lit_r5_valid",  32'(o_rsp_valid),  32'(1));
        chk("lit_r5_rdata",  32'(o_rsp_rdata),  32'h01);
        chk("lit_r5_flags",  {30'd0, o_rsp_corr, o_rsp_uncorr}, 32'(0));

        wr(8'd6, 8'hFF);
        idle(1);
        chk("lit_wff_din", 32'(o_mem_din), 32'hF77);
        wr(8'd7, 8'h00);
        idle(1);
        chk("lit_w00_din", 32'(o_mem_din), 32'h000);
        chk("lit_w00_we",  32'(o_mem_we),  32'(1));
        idle(3);

        rd(8'd202);
        idle(5);
        chk("lit_c027_rdata", 32'(o_rsp_rdata), 32'h01);
        chk("lit_c027_corr",  32'(o_rsp_corr),  32'(1));
        chk("lit_c027_cnt",   32'(o_corr_cnt),  32'(1));
        rd(8'd203);
        idle(5);
        chk("lit_u803_rdata",  32'(o_rsp_rdata),  32'h80);
        chk("lit_u803_uncorr", 32'(o_rsp_uncorr), 32'(1));
        chk("lit_u803_corr",   32'(o_rsp_corr),   32'(0));
        chk("lit_u803_cnt",    32'(o_corr_cnt),   32'(1));

        wr(8'd3, 8'h5A);
        n_wait = 0;
        do begin
            rd(8'd3);
            n_wait++;
        end while (!o_req_ready && n_wait < 10);
        chk("lit_raw_wait", 32'(n_wait), 32'(3));
        idle(5);
        chk("lit_raw_rdata", 32'(o_rsp_rdata), 32'h5A);
        idle(2);

        rsp_seen = 0;
        for (int i = 0; i < 8; i++) begin
            rd(8'(i));
            if (i == 4) chk("lit_burst_early", 32'(o_rsp_valid), 32'(0));
            if (i == 5) chk("lit_burst_first", 32'(o_rsp_valid), 32'(1));
        end
        idle(12);
        chk("lit_burst_count", 32'(rsp_seen), 32'(8));

        rsp_seen = 0;
        for (int i = 0; i < 8; i++) rd(8'(i));
        step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        chk("lit_rst_drop", 32'(o_rsp_valid), 32'(0));
        step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
        idle(12);
        chk("lit_rst_no_stale", 32'(rsp_seen), 32'(3));

        for (int i = 0; i < 260; i++) rd(8'd202);
        idle(6);
        chk("lit_cnt_sat", 32'(o_corr_cnt), 32'd255);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) ra = 8'(200 + $urandom_range(0, 3));
            else                           ra = 8'($urandom_range(0, 15));
            step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)), ra, 8'($urandom), 1'b0);
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
